// File: rtl/sample_msg_combiner_pkg.sv
// ============================================================================
// sample_msg_combiner_pkg : header-field definitions shared with the splitter
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

// Length field of a header word sits just below the header flag.
`define MSG_HDR_LEN(word, width) word[(width)-2 -: `MSG_LENGTH_WIDTH]

package sample_msg_combiner_pkg;

    localparam int MSG_LEN_W = `MSG_LENGTH_WIDTH;

    typedef enum logic [1:0] {
        IN_EXPECT_HDR = 2'd0,
        IN_BODY       = 2'd1,
        IN_DISCARD    = 2'd2
    } in_state_e;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_MSG  = 1'b1
    } out_state_e;

    function automatic int msg_hdr_bit(input int width);
        return width - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_msg_combiner_fifo.sv
// ============================================================================
// msg_rewind_fifo : synchronous FIFO with write-pointer rewind and commit count
// Revision: 1.0
// ============================================================================
`default_nettype none

module msg_rewind_fifo #(
    parameter int WIDTH       = 32,
    parameter int LOG         = 4,
    parameter bit AUTO_COMMIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rewind_i,
    input  logic [LOG:0]     rewind_ptr_i,
    input  logic             commit_i,
    input  logic             release_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LOG:0]     wr_ptr_o,
    output logic             full_o,
    output logic             avail_o
);

    localparam int DEPTH = 1 << LOG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG:0]     wr_ptr_q, wr_ptr_d;
    logic [LOG:0]     rd_ptr_q, rd_ptr_d;
    logic [LOG:0]     eff_wr_ptr;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    // A rewind applies in the same cycle, so a write may land on the rewound slot.
    assign eff_wr_ptr = rewind_i ? rewind_ptr_i : wr_ptr_q;
    assign full_o     = (eff_wr_ptr[LOG] != rd_ptr_q[LOG]) &&
                        (eff_wr_ptr[LOG-1:0] == rd_ptr_q[LOG-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign do_wr      = wr_en_i & ~full_o;
    assign do_rd      = rd_en_i & avail_o;
    assign wr_ptr_d   = do_wr ? eff_wr_ptr + 1'b1 : eff_wr_ptr;
    assign rd_ptr_d   = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign wr_ptr_o   = eff_wr_ptr;
    assign rd_data_o  = mem_q[rd_ptr_q[LOG-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[eff_wr_ptr[LOG-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    generate
        if (AUTO_COMMIT) begin : g_auto_commit
            logic unused_commit;
            assign unused_commit = commit_i ^ release_i;
            assign avail_o       = ~empty;
        end else begin : g_commit_count
            // Only committed messages are readable; uncommitted tail may be rewound.
            logic [LOG:0] count_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + {{LOG{1'b0}}, commit_i} - {{LOG{1'b0}}, release_i};
                end
            end
            assign avail_o = ~empty && (count_q != '0);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sample_msg_combiner.sv
// ============================================================================
// sample_msg_combiner : merges a sample stream and a message stream into one
// Optional: SAMPLE_MSG_COMBINER_SAMPLE_PRIORITY_EN gives waiting samples priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_msg_combiner
    import sample_msg_combiner_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SAMPLE_BUF_LOG = 4,
    parameter int MSG_BUF_LOG    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_samples,
    input  logic             in_samples_nd,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_msg_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);

    localparam int HDR_BIT = msg_hdr_bit(WIDTH);

    in_state_e                in_state_q, in_state_d;
    logic [MSG_LEN_W-1:0]     remaining_q, remaining_d;
    logic [MSG_BUF_LOG:0]     start_ptr_q, start_ptr_d;
    out_state_e               out_state_q, out_state_d;
    logic [MSG_LEN_W-1:0]     out_rem_q, out_rem_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    logic                     out_nd_q, out_nd_d;
    logic                     error_q, error_d;

    logic                     s_wr, s_bad, s_full, s_avail, s_rd;
    logic [WIDTH-1:0]         s_rd_data;
    logic [SAMPLE_BUF_LOG:0]  s_wr_ptr_unused;

    logic                     m_wr, m_rewind, m_commit, m_err, m_full, m_avail, m_rd, m_release;
    logic [WIDTH-1:0]         m_rd_data;
    logic [MSG_BUF_LOG:0]     m_wr_ptr;
    logic [MSG_LEN_W-1:0]     in_len, out_len;
    logic                     pick_msg, pick_sample;

    assign s_bad = in_samples_nd & (in_samples[HDR_BIT] | s_full);
    assign s_wr  = in_samples_nd & ~in_samples[HDR_BIT] & ~s_full;

    msg_rewind_fifo #(
        .WIDTH       (WIDTH),
        .LOG         (SAMPLE_BUF_LOG),
        .AUTO_COMMIT (1'b1)
    ) u_sample_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (s_wr),
        .wr_data_i    (in_samples),
        .rewind_i     (1'b0),
        .rewind_ptr_i ('0),
        .commit_i     (1'b0),
        .release_i    (1'b0),
        .rd_en_i      (s_rd),
        .rd_data_o    (s_rd_data),
        .wr_ptr_o     (s_wr_ptr_unused),
        .full_o       (s_full),
        .avail_o      (s_avail)
    );

    msg_rewind_fifo #(
        .WIDTH       (WIDTH),
        .LOG         (MSG_BUF_LOG),
        .AUTO_COMMIT (1'b0)
    ) u_msg_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (m_wr),
        .wr_data_i    (in_msg),
        .rewind_i     (m_rewind),
        .rewind_ptr_i (start_ptr_q),
        .commit_i     (m_commit),
        .release_i    (m_release),
        .rd_en_i      (m_rd),
        .rd_data_o    (m_rd_data),
        .wr_ptr_o     (m_wr_ptr),
        .full_o       (m_full),
        .avail_o      (m_avail)
    );

    assign in_len  = `MSG_HDR_LEN(in_msg, WIDTH);
    assign out_len = `MSG_HDR_LEN(m_rd_data, WIDTH);

    // DISCARD keeps the pointer parked at the abandoned message start.
    assign m_rewind = (in_state_q == IN_DISCARD) |
                      (in_msg_nd & in_msg[HDR_BIT] & (in_state_q == IN_BODY));

    always_comb begin
        in_state_d  = in_state_q;
        remaining_d = remaining_q;
        start_ptr_d = start_ptr_q;
        m_wr        = 1'b0;
        m_commit    = 1'b0;
        m_err       = 1'b0;
        if (in_msg_nd) begin
            if (in_msg[HDR_BIT]) begin
                if (in_state_q == IN_BODY) begin
                    m_err = 1'b1;
                end
                start_ptr_d = m_wr_ptr;
                if (m_full) begin
                    m_err      = 1'b1;
                    in_state_d = IN_DISCARD;
                end else begin
                    m_wr = 1'b1;
                    if (in_len == '0) begin
                        m_commit   = 1'b1;
                        in_state_d = IN_EXPECT_HDR;
                    end else begin
                        remaining_d = in_len;
                        in_state_d  = IN_BODY;
                    end
                end
            end else begin
                case (in_state_q)
                    IN_BODY: begin
                        if (m_full) begin
                            m_err      = 1'b1;
                            in_state_d = IN_DISCARD;
                        end else begin
                            m_wr        = 1'b1;
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == MSG_LEN_W'(1)) begin
                                m_commit   = 1'b1;
                                in_state_d = IN_EXPECT_HDR;
                            end
                        end
                    end
                    IN_EXPECT_HDR: m_err = 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef SAMPLE_MSG_COMBINER_SAMPLE_PRIORITY_EN
    assign pick_sample = s_avail;
    assign pick_msg    = m_avail & ~s_avail;
`else
    assign pick_msg    = m_avail;
    assign pick_sample = s_avail & ~m_avail;
`endif

    always_comb begin
        out_state_d = out_state_q;
        out_rem_d   = out_rem_q;
        out_data_d  = out_data_q;
        out_nd_d    = 1'b0;
        s_rd        = 1'b0;
        m_rd        = 1'b0;
        m_release   = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (pick_msg) begin
                    m_rd       = 1'b1;
                    out_data_d = m_rd_data;
                    out_nd_d   = 1'b1;
                    out_rem_d  = out_len;
                    if (out_len == '0) begin
                        m_release = 1'b1;
                    end else begin
                        out_state_d = OUT_MSG;
                    end
                end else if (pick_sample) begin
                    s_rd       = 1'b1;
                    out_data_d = s_rd_data;
                    out_nd_d   = 1'b1;
                end
            end
            OUT_MSG: begin
                m_rd       = 1'b1;
                out_data_d = m_rd_data;
                out_nd_d   = 1'b1;
                out_rem_d  = out_rem_q - 1'b1;
                if (out_rem_q == MSG_LEN_W'(1)) begin
                    m_release   = 1'b1;
                    out_state_d = OUT_IDLE;
                end
            end
            default: ;
        endcase
    end

    assign error_d = error_q | s_bad | m_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q  <= IN_EXPECT_HDR;
            remaining_q <= '0;
            start_ptr_q <= '0;
            out_state_q <= OUT_IDLE;
            out_rem_q   <= '0;
            out_data_q  <= '0;
            out_nd_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            remaining_q <= remaining_d;
            start_ptr_q <= start_ptr_d;
            out_state_q <= out_state_d;
            out_rem_q   <= out_rem_d;
            out_data_q  <= out_data_d;
            out_nd_q    <= out_nd_d;
            error_q     <= error_d;
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_msg_combiner.sv
// ============================================================================
// tb_sample_msg_combiner : directed and randomized checks of the stream merger
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_msg_combiner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_samples = '0;
    logic        in_samples_nd = 1'b0;
    logic [31:0] in_msg = '0;
    logic        in_msg_nd = 1'b0;
    logic [31:0] out_data;
    logic        out_nd;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] mon_data[$];
    int          mon_cyc[$];

    sample_msg_combiner #(
        .WIDTH          (32),
        .SAMPLE_BUF_LOG (4),
        .MSG_BUF_LOG    (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_samples    (in_samples),
        .in_samples_nd (in_samples_nd),
        .in_msg        (in_msg),
        .in_msg_nd     (in_msg_nd),
        .out_data      (out_data),
        .out_nd        (out_nd),
        .error         (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_nd === 1'b1) begin
            mon_data.push_back(out_data);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        in_samples_nd = 1'b0;
        in_msg_nd     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit s_nd, input logic [31:0] s, input bit m_nd, input logic [31:0] m);
        in_samples_nd = s_nd;
        in_samples    = s;
        in_msg_nd     = m_nd;
        in_msg        = m;
        @(posedge clk);
        #1;
        in_samples_nd = 1'b0;
        in_msg_nd     = 1'b0;
    endtask

    task automatic reset_dut;
        in_samples_nd = 1'b0;
        in_msg_nd     = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic test_reset;
        reset_dut();
        n_tests++;
        if (out_nd !== 1'b0) begin n_fail++; $display("FAIL reset_out_nd: got %b expected 0", out_nd); end
        n_tests++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    endtask

    task automatic test_samples;
        int c0;
        reset_dut();
        c0 = cyc;
        for (int i = 1; i <= 3; i++) send(1'b1, 32'(i), 1'b0, 32'h0);
        idle(6);
        n_tests++;
        if (mon_data.size() != 3) begin
            n_fail++; $display("FAIL samples_count: got %0d expected 3", mon_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (mon_data[i] !== 32'(i + 1) || mon_cyc[i] != c0 + 2 + i) begin
                    n_fail++;
                    $display("FAIL samples_word%0d: got %h@%0d expected %h@%0d", i, mon_data[i], mon_cyc[i], i + 1, c0 + 2 + i);
                end
            end
        end
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL samples_error: got %b expected 0", error); end
    endtask

    task automatic test_msg_with_samples;
        logic [31:0] exp_q[$];
        int c0;
        reset_dut();
`ifdef SAMPLE_MSG_COMBINER_SAMPLE_PRIORITY_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h10 + 32'(i));
        exp_q.push_back(32'h8180_0000); exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
`else
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h10 + 32'(i));
        exp_q.push_back(32'h8180_0000); exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
        for (int i = 3; i < 8; i++) exp_q.push_back(32'h10 + 32'(i));
`endif
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'h10 + 32'(i), i < 4, (i == 0) ? 32'h8180_0000 : 32'h9 + 32'(i));
        end
        idle(20);
        n_tests++;
        if (mon_data.size() != exp_q.size()) begin
            n_fail++; $display("FAIL mixed_count: got %0d expected %0d", mon_data.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (mon_data[i] !== exp_q[i] || mon_cyc[i] != c0 + 2 + i) begin
                    n_fail++;
                    $display("FAIL mixed_word%0d: got %h@%0d expected %h@%0d", i, mon_data[i], mon_cyc[i], exp_q[i], c0 + 2 + i);
                end
            end
        end
    endtask

    task automatic test_zero_len;
        int c0;
        reset_dut();
        c0 = cyc;
        send(1'b0, 32'h0, 1'b1, 32'h8000_0000);
        idle(6);
        n_tests++;
        if (mon_data.size() != 1 || mon_data[0] !== 32'h8000_0000 || mon_cyc[0] != c0 + 2) begin
            n_fail++;
            $display("FAIL zero_len: got %0d words first %h@%0d expected 1 word 80000000@%0d",
                     mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'h0,
                     (mon_cyc.size() > 0) ? mon_cyc[0] : -1, c0 + 2);
        end
        mon_data.delete(); mon_cyc.delete();
        c0 = cyc;
        send(1'b1, 32'h42, 1'b0, 32'h0);
        idle(5);
        n_tests++;
        if (mon_data.size() != 1 || mon_data[0] !== 32'h42 || mon_cyc[0] != c0 + 2) begin
            n_fail++; $display("FAIL zero_len_then_sample: got %0d words expected 00000042@%0d", mon_data.size(), c0 + 2);
        end
    endtask

    task automatic test_overflow;
        int c0;
        reset_dut();
        send(1'b0, 32'h0, 1'b1, 32'hB200_0000);
        for (int i = 0; i < 63; i++) send(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i));
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL overflow_exact_fill: got error %b expected 0", error); end
        send(1'b0, 32'h0, 1'b1, 32'h200);
        n_tests++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_error: got error %b expected 1", error); end
        for (int i = 0; i < 4; i++) send(1'b0, 32'h0, 1'b1, 32'h300 + 32'(i));
        send(1'b0, 32'h0, 1'b1, 32'h8080_0000);
        c0 = cyc;
        send(1'b0, 32'h0, 1'b1, 32'h7);
        idle(6);
        n_tests++;
        if (mon_data.size() != 2) begin
            n_fail++; $display("FAIL overflow_out_count: got %0d expected 2", mon_data.size());
        end else begin
            n_tests++;
            if (mon_data[0] !== 32'h8080_0000 || mon_data[1] !== 32'h7 ||
                mon_cyc[0] != c0 + 2 || mon_cyc[1] != c0 + 3) begin
                n_fail++;
                $display("FAIL overflow_next_msg: got %h@%0d %h@%0d expected 80800000@%0d 00000007@%0d",
                         mon_data[0], mon_cyc[0], mon_data[1], mon_cyc[1], c0 + 2, c0 + 3);
            end
        end
    endtask

    task automatic test_illegal;
        reset_dut();
        send(1'b0, 32'h0, 1'b1, 32'h5);
        idle(4);
        n_tests++;
        if (error !== 1'b1 || mon_data.size() != 0) begin
            n_fail++; $display("FAIL stray_content: got error %b words %0d expected 1 and 0", error, mon_data.size());
        end
        reset_dut();
        send(1'b1, 32'h8000_0001, 1'b0, 32'h0);
        idle(4);
        n_tests++;
        if (error !== 1'b1 || mon_data.size() != 0) begin
            n_fail++; $display("FAIL bad_sample: got error %b words %0d expected 1 and 0", error, mon_data.size());
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        int waited;
        reset_dut();
        send(1'b0, 32'h0, 1'b1, 32'h5);
        send(1'b0, 32'h0, 1'b1, 32'h8500_0000);
        for (int i = 1; i <= 10; i++) send(1'b0, 32'h0, 1'b1, 32'(i));
        waited = 0;
        while (mon_data.size() < 3 && waited < 20) begin
            idle(1);
            waited++;
        end
        n_tests++;
        if (mon_data.size() < 3) begin
            n_fail++; $display("FAIL reset_mid_timeout: got %0d words expected >= 3", mon_data.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_nd !== 1'b0 || error !== 1'b0 || out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_async: got nd %b err %b data %h expected 0 0 0", out_nd, error, out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        mon_data.delete(); mon_cyc.delete();
        c0 = cyc;
        send(1'b1, 32'h9, 1'b0, 32'h0);
        idle(15);
        n_tests++;
        if (mon_data.size() != 1 || mon_data[0] !== 32'h9 || mon_cyc[0] != c0 + 2) begin
            n_fail++; $display("FAIL reset_mid_after: got %0d words expected 00000009@%0d only", mon_data.size(), c0 + 2);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_samp[$];
        logic [31:0] committed[$];
        logic [31:0] cur[$];
        int          need;
        bit          active;
        bit          exp_err;
        int          gen_rem;
        int          i;
        int          k;
        bit          s_nd, m_nd, make_hdr;
        logic [31:0] s, m, got, want;
        int          len;
        reset_dut();
        need = 0; active = 0; exp_err = 0; gen_rem = 0; i = 0;
        while (i < 600 || gen_rem > 0) begin
            s_nd = (i < 600) && ($urandom_range(0, 4) == 0);
            s = $urandom & 32'h7FFF_FFFF;
            m_nd = ($urandom_range(0, 1) == 0);
            m = 32'h0;
            make_hdr = 1'b0;
            if (m_nd) begin
                if (gen_rem == 0) begin
                    if (i < 600 && $urandom_range(0, 15) == 0) m = $urandom & 32'h7FFF_FFFF;
                    else make_hdr = 1'b1;
                end else if (i < 600 && $urandom_range(0, 19) == 0) begin
                    make_hdr = 1'b1;
                end else begin
                    m = $urandom & 32'h7FFF_FFFF;
                    gen_rem--;
                end
                if (make_hdr) begin
                    len = (i < 600) ? $urandom_range(0, 6) : 0;
                    m = 32'h8000_0000 | (32'(len) << 23) | ($urandom & 32'h007F_FFFF);
                    gen_rem = len;
                end
                // Reference: a message is kept only once all its declared words arrive.
                if (m[31]) begin
                    if (active) begin exp_err = 1'b1; cur.delete(); end
                    cur.delete();
                    cur.push_back(m);
                    need = int'(m[30:23]);
                    active = (need > 0);
                    if (!active) committed.push_back(m);
                end else if (!active) begin
                    exp_err = 1'b1;
                end else begin
                    cur.push_back(m);
                    need--;
                    if (need == 0) begin
                        foreach (cur[j]) committed.push_back(cur[j]);
                        cur.delete();
                        active = 1'b0;
                    end
                end
            end
            if (s_nd) exp_samp.push_back(s);
            send(s_nd, s, m_nd, m);
            i++;
        end
        idle(120);
        k = 0;
        while (k < mon_data.size()) begin
            got = mon_data[k];
            if (got[31]) begin
                want = (committed.size() > 0) ? committed.pop_front() : 32'hDEAD_BEEF;
                n_tests++;
                if (got !== want) begin n_fail++; $display("FAIL rand_header: got %h expected %h", got, want); end
                len = int'(got[30:23]);
                for (int j = 1; j <= len; j++) begin
                    want = (committed.size() > 0) ? committed.pop_front() : 32'hDEAD_BEEF;
                    n_tests++;
                    if (k + j >= mon_data.size()) begin
                        n_fail++; $display("FAIL rand_content_missing: got none expected %h", want);
                    end else if (mon_data[k + j] !== want || mon_cyc[k + j] != mon_cyc[k] + j) begin
                        n_fail++;
                        $display("FAIL rand_content: got %h@%0d expected %h@%0d", mon_data[k + j], mon_cyc[k + j], want, mon_cyc[k] + j);
                    end
                end
                k += len + 1;
            end else begin
                want = (exp_samp.size() > 0) ? exp_samp.pop_front() : 32'hDEAD_BEEF;
                n_tests++;
                if (got !== want) begin n_fail++; $display("FAIL rand_sample: got %h expected %h", got, want); end
                k++;
            end
        end
        n_tests++;
        if (exp_samp.size() != 0 || committed.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d samples %0d msg words left expected 0 0", exp_samp.size(), committed.size());
        end
        n_tests++;
        if (error !== exp_err) begin n_fail++; $display("FAIL rand_error: got %b expected %b", error, exp_err); end
    endtask

    initial begin
        test_reset();
        test_samples();
        test_msg_with_samples();
        test_zero_len();
        test_overflow();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sample_msg_combiner.md
Name: sample_msg_combiner

Overview:
Upstream counterpart of the sample/message splitter. It merges a sample stream and a message stream into one mixed stream.
- Message header: bit WIDTH-1 = 1; length field at [WIDTH-2 -: `MSG_LENGTH_WIDTH].
- Samples and message contents: bit WIDTH-1 = 0.
- Both inputs are buffered. A message is emitted only once it is complete, and always as one contiguous run, never interleaved with samples.

Parameters:
WIDTH, 32, word width of all data ports.
SAMPLE_BUF_LOG, 4, log2 of sample FIFO depth (16).
MSG_BUF_LOG, 6, log2 of message FIFO depth (64).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_samples  in  WIDTH  sample word.
in_samples_nd  in  1  in_samples valid this cycle.
in_msg  in  WIDTH  message header or content word.
in_msg_nd  in  1  in_msg valid this cycle.
out_data  out  WIDTH  merged stream word, registered.
out_nd  out  1  out_data valid this cycle, registered.
error  out  1  sticky; set on any dropped or illegal word.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_nd=0, error=0, both FIFOs empty, complete-message count 0, input-side state EXPECT_HDR, output state IDLE. Reset mid-message truncates output; the downstream splitter shares rst_n.
- Sample input: in_samples_nd writes to the sample FIFO.
  - MSB=1: word dropped, error set.
  - FIFO full: word dropped, error set.
- Message input FSM, states EXPECT_HDR / IN_BODY / DISCARD:
  - EXPECT_HDR, header with len L: save msg FIFO write pointer as start_ptr, write header. L=0: commit now, stay in EXPECT_HDR. L>0: remaining=L, go to IN_BODY.
  - EXPECT_HDR, content word: drop, error.
  - IN_BODY, content word: write, remaining-1. On the last word: commit, go to EXPECT_HDR.
  - IN_BODY, header word: error; rewind write pointer to start_ptr; treat the new word as a header from EXPECT_HDR in the same cycle.
  - Any write while msg FIFO full: error, rewind to start_ptr, go to DISCARD. DISCARD drops words until the next header, which is handled as in EXPECT_HDR.
  - Commit: increment complete_count. Uncommitted words are never read.
- Output FSM, states IDLE / MSG:
  - IDLE, complete_count>0: pop header, load out_remaining = header length, emit header. Length nonzero: go to MSG.
  - IDLE, otherwise: if sample FIFO is non-empty, pop and emit one sample.
  - MSG: pop and emit one content word per cycle. After the last word, decrement complete_count and go to IDLE. A header popped with length 0 decrements complete_count in the same cycle.
  - A simultaneous commit and completion leaves complete_count unchanged.
  - Throughput: 1 word/cycle; out_nd low when nothing is eligible.
- Latency:
  - Sample with in_samples_nd in cycle 0, idle block: out_nd in cycle 2.
  - Message whose last word arrives in cycle n: header out in cycle n+2, contents in cycles n+3 onward, back-to-back.
- Ordering: samples leave in arrival order; messages leave in commit order.
- Pointers: binary with one extra wrap bit; full/empty from pointer compare; wrap-around is seamless.

Optional Feature:
SAMPLE_MSG_COMBINER_SAMPLE_PRIORITY_EN.
- Defined: in IDLE, a waiting sample beats a complete message. A message starts only when the sample FIFO is empty; once started it is never interrupted.
- Undefined: complete messages have priority, as above.

Decomposition:
- Shared package/include: `MSG_LENGTH_WIDTH`, header-flag bit position, and a length-field extract macro, shared with the splitter.
- One sub-module, msg_rewind_fifo: synchronous FIFO with a write-pointer load port (rewind) and separate commit tracking. It is instantiated for both buffers; the sample instance ties rewind off.

Test Plan:
1. `MSG_LENGTH_WIDTH=8. Samples 0x1, 0x2, 0x3 in cycles 0-2 -> out 0x1, 0x2, 0x3 in cycles 2-4, error=0.
2. Continuous samples 0x10.. plus header 0x81800000 with contents 0xA, 0xB, 0xC -> contiguous 0x81800000, 0xA, 0xB, 0xC; samples resume in order, none lost.
3. Zero-length header 0x80000000 alone -> emitted 2 cycles later, single word, then IDLE.
4. MSG_BUF_LOG=2, header length 5 with contents -> error=1, no word of it emitted; next header 0x80800000 with content 0x7 -> emitted normally.
5. Content 0x5 on in_msg with no header -> dropped, error=1. Sample 0x80000001 -> dropped, error=1.
6. Assert rst_n low mid-message output -> out_nd=0 immediately, error=0. After release, sample 0x9 -> out 2 cycles later.
7. With SAMPLE_MSG_COMBINER_SAMPLE_PRIORITY_EN defined, rerun scenario 2 -> message emitted only after sample FIFO drains.
